// File: rtl/counter_pkg.sv
// Shared constants for the up/down counter family: direction encoding on `up`
// and the wrap/saturate mode selector used by the SATURATE parameter.
package counter_pkg;

    localparam logic DIR_UP   = 1'b1;
    localparam logic DIR_DOWN = 1'b0;

    localparam int MODE_WRAP = 0;
    localparam int MODE_SAT  = 1;

endpackage

// File: rtl/counter_step.sv
// Combinational next-count for one enabled step, including the boundary
// wrap/saturate decision; o_wrap flags a modulus rollover in either direction.
module counter_step
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic [WIDTH-1:0] i_count,
    input  logic             i_up,
    output logic [WIDTH-1:0] o_next_count,
    output logic             o_wrap
);

    // One extra bit keeps the compare exact even when MAX_VALUE fills WIDTH.
    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH:0] w_cnt_ext;

    assign w_cnt_ext = {1'b0, i_count};

    always_comb begin
        o_next_count = i_count;
        o_wrap       = 1'b0;
        if (i_up == DIR_UP) begin
            if (w_cnt_ext < MAX_EXT) begin
                o_next_count = i_count + WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
                o_next_count = '0;
                o_wrap       = 1'b1;
            end
        end else begin
            if (w_cnt_ext != '0) begin
                o_next_count = i_count - WIDTH'(1);
            end else if (SATURATE == MODE_WRAP) begin
                o_next_count = MAX_W;
                o_wrap       = 1'b1;
            end
        end
    end

endmodule

// File: rtl/mod_updown_counter.sv
// Parametrised up/down counter with modulus MAX_VALUE+1, clamped parallel load,
// wrap or saturate at the ends, and a registered one-cycle terminal-count pulse.
module mod_updown_counter
    import counter_pkg::*;
#(
    parameter int          WIDTH     = 4,
    parameter int unsigned MAX_VALUE = 2**WIDTH - 1,
    parameter int          SATURATE  = MODE_WRAP
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             clr,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    input  logic             en,
    input  logic             up,
    output logic [WIDTH-1:0] count,
    output logic             tc,
    output logic             at_max,
    output logic             at_zero
);

    localparam logic [WIDTH:0]   MAX_EXT = (WIDTH+1)'(MAX_VALUE);
    localparam logic [WIDTH-1:0] MAX_W   = MAX_EXT[WIDTH-1:0];

    logic [WIDTH-1:0] r_count;
    logic             r_tc;
    logic [WIDTH-1:0] w_next_count;
    logic             w_wrap;
    logic [WIDTH-1:0] w_load_clamped;

    counter_step #(
        .WIDTH     (WIDTH),
        .MAX_VALUE (MAX_VALUE),
        .SATURATE  (SATURATE)
    ) u_step (
        .i_count      (r_count),
        .i_up         (up),
        .o_next_count (w_next_count),
        .o_wrap       (w_wrap)
    );

    // Out-of-range loads clamp so the count never exceeds MAX_VALUE.
    assign w_load_clamped = ({1'b0, load_val} > MAX_EXT) ? MAX_W : load_val;

    always_ff @(posedge clk) begin
        if (rst) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (clr) begin
            r_count <= '0;
            r_tc    <= 1'b0;
        end else if (load) begin
            r_count <= w_load_clamped;
            r_tc    <= 1'b0;
        end else if (en) begin
            r_count <= w_next_count;
            r_tc    <= w_wrap;
        end else begin
            r_tc    <= 1'b0;
        end
    end

    assign count   = r_count;
    assign tc      = r_tc;
    assign at_max  = (r_count == MAX_W);
    assign at_zero = (r_count == '0);

endmodule

// File: tb/tb_mod_updown_counter.sv
// Directed bench: wrapping and saturating counters plus a two-stage decade cascade.
module tb_mod_updown_counter;

    logic clk = 1'b0;
    logic rst = 1'b0;
    always #5 clk = ~clk;

    // Wrapping instance (MAX_VALUE = 9)
    logic       w_clr = 0, w_load = 0, w_en = 0, w_up = 1;
    logic [3:0] w_load_val = '0;
    logic [3:0] w_count;
    logic       w_tc, w_at_max, w_at_zero;

    // Saturating instance (MAX_VALUE = 9)
    logic       s_clr = 0, s_load = 0, s_en = 0, s_up = 1;
    logic [3:0] s_load_val = '0;
    logic [3:0] s_count;
    logic       s_tc, s_at_max, s_at_zero;

    // Cascade: stage 1 enabled by stage 0 terminal count
    logic       c_en = 0;
    logic [3:0] c0_count, c1_count;
    logic       c0_tc, c1_tc, c0_at_max, c0_at_zero, c1_at_max, c1_at_zero;

    mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0)) u_wrap (
        .clk(clk), .rst(rst), .clr(w_clr), .load(w_load), .load_val(w_load_val),
        .en(w_en), .up(w_up), .count(w_count), .tc(w_tc),
        .at_max(w_at_max), .at_zero(w_at_zero)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(1)) u_sat (
        .clk(clk), .rst(rst), .clr(s_clr), .load(s_load), .load_val(s_load_val),
        .en(s_en), .up(s_up), .count(s_count), .tc(s_tc),
        .at_max(s_at_max), .at_zero(s_at_zero)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0)) u_c0 (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(c_en), .up(1'b1), .count(c0_count), .tc(c0_tc),
        .at_max(c0_at_max), .at_zero(c0_at_zero)
    );

    mod_updown_counter #(.WIDTH(4), .MAX_VALUE(9), .SATURATE(0)) u_c1 (
        .clk(clk), .rst(rst), .clr(1'b0), .load(1'b0), .load_val(4'd0),
        .en(c0_tc), .up(1'b1), .count(c1_count), .tc(c1_tc),
        .at_max(c1_at_max), .at_zero(c1_at_zero)
    );

    int checks = 0;
    int passes = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) passes++;
        else $error("FAIL %s: observed %0d expected %0d", tag, obs, exp);
    endtask

    // Advance one edge, then settle just past it for both driving and sampling.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int exp_c0, exp_c1, exp_tc0, exp_tc1, n0, n1, tc1_pulses;

        // Reset state
        #1;
        rst = 1;
        tick();
        rst = 0;
        check("rst_count", 32'(w_count), 0);
        check("rst_tc", 32'(w_tc), 0);
        check("rst_at_zero", 32'(w_at_zero), 1);
        check("rst_at_max", 32'(w_at_max), 0);
        check("rst_sat_count", 32'(s_count), 0);
        check("rst_c1_count", 32'(c1_count), 0);

        // Free-running up count with wrap every 10 cycles
        w_en = 1; w_up = 1;
        for (int i = 1; i <= 20; i++) begin
            tick();
            check("up_count", 32'(w_count), 32'(i % 10));
            check("up_tc", 32'(w_tc), 32'((i % 10) == 0));
            check("up_at_max", 32'(w_at_max), 32'((i % 10) == 9));
        end

        // Down count from reset: 0 -> 9 with tc, then 8, 7, ...
        w_up = 0; rst = 1;
        tick();
        rst = 0;
        check("dn_rst_count", 32'(w_count), 0);
        for (int i = 1; i <= 11; i++) begin
            tick();
            check("dn_count", 32'(w_count), 32'((20 - i) % 10));
            check("dn_tc", 32'(w_tc), 32'(i == 1 || i == 11));
        end

        // Mid-operation reset at count 6, then resume with no tc
        w_up = 1; rst = 1;
        tick();
        rst = 0;
        for (int i = 1; i <= 6; i++) tick();
        check("mid_pre_count", 32'(w_count), 6);
        rst = 1;
        tick();
        rst = 0;
        check("mid_rst_count", 32'(w_count), 0);
        check("mid_rst_tc", 32'(w_tc), 0);
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("mid_resume_count", 32'(w_count), 32'(i));
            check("mid_resume_tc", 32'(w_tc), 0);
        end

        // Load clamp and priority (en still high)
        w_load = 1; w_load_val = 4'd14;
        tick();
        check("load_clamp_count", 32'(w_count), 9);
        check("load_clamp_tc", 32'(w_tc), 0);
        check("load_clamp_at_max", 32'(w_at_max), 1);
        w_load_val = 4'd3;
        tick();
        check("load_beats_en", 32'(w_count), 3);
        w_load_val = 4'd9;
        tick();
        w_load = 0;
        tick();
        check("wrap_after_load", 32'(w_count), 0);
        check("wrap_after_load_tc", 32'(w_tc), 1);
        w_clr = 1; w_load = 1; w_load_val = 4'd5;
        tick();
        check("clr_beats_load", 32'(w_count), 0);
        w_clr = 0; w_load_val = 4'd9;
        tick();
        check("load9", 32'(w_count), 9);
        rst = 1; w_clr = 1; w_load = 1; w_load_val = 4'd7;
        tick();
        check("rst_beats_all_count", 32'(w_count), 0);
        check("rst_beats_all_tc", 32'(w_tc), 0);
        rst = 0; w_clr = 0; w_load = 0; w_en = 0;
        tick();
        check("idle_hold", 32'(w_count), 0);

        // Saturate: load 8, three up steps stick at 9
        s_load = 1; s_load_val = 4'd8;
        tick();
        check("sat_load", 32'(s_count), 8);
        s_load = 0; s_en = 1; s_up = 1;
        for (int i = 1; i <= 3; i++) begin
            tick();
            check("sat_up_count", 32'(s_count), 9);
            check("sat_up_tc", 32'(s_tc), 0);
            check("sat_up_at_max", 32'(s_at_max), 1);
        end
        s_up = 0;
        for (int i = 1; i <= 12; i++) begin
            tick();
            check("sat_dn_count", 32'(s_count), 32'((i < 9) ? 9 - i : 0));
            check("sat_dn_tc", 32'(s_tc), 0);
        end
        check("sat_dn_at_zero", 32'(s_at_zero), 1);
        s_en = 0;

        // Cascade: 100 enabled clocks, then one more edge lets stage 1 roll to 0
        rst = 1;
        tick();
        rst = 0;
        exp_c0 = 0; exp_c1 = 0; exp_tc0 = 0; exp_tc1 = 0; tc1_pulses = 0;
        c_en = 1;
        for (int i = 1; i <= 101; i++) begin
            if (i == 101) c_en = 0;
            n1 = exp_c1; exp_tc1 = 0;
            if (exp_tc0 == 1) begin
                if (exp_c1 == 9) begin n1 = 0; exp_tc1 = 1; end
                else n1 = exp_c1 + 1;
            end
            n0 = exp_c0; exp_tc0 = 0;
            if (i <= 100) begin
                if (exp_c0 == 9) begin n0 = 0; exp_tc0 = 1; end
                else n0 = exp_c0 + 1;
            end
            exp_c0 = n0; exp_c1 = n1;
            tick();
            if (c1_tc) tc1_pulses++;
            if (i % 10 == 0 || i >= 99) begin
                check("casc_c0", 32'(c0_count), 32'(exp_c0));
                check("casc_c1", 32'(c1_count), 32'(exp_c1));
                check("casc_tc1", 32'(c1_tc), 32'(exp_tc1));
            end
        end
        check("casc_final_c0", 32'(c0_count), 0);
        check("casc_final_c1", 32'(c1_count), 0);
        check("casc_tc1_pulses", 32'(tc1_pulses), 1);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
